// File: rtl/system_qsys_pio_lcd_data_in.sv
// Avalon-MM input PIO for the LCD data bus. It synchronizes the bus, can debounce it
// as a whole word, keeps sticky per-bit edge flags and drives a maskable level irq.
module system_qsys_pio_lcd_data_in #(
  parameter int WIDTH     = 16,
  parameter int DEBOUNCE  = 0,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Bus handshake: there is no wait-request. A write happens at any clk edge where
  // chipselect && !write_n. readdata is registered from address on every edge, so a
  // read has a fixed latency of 1 and no side effects.

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] data_q, data_dly_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] ev, clr;
  logic [31:0]      readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= s2_q;
      end
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
      logic [WIDTH-1:0] cand_q;
      logic [CW-1:0]    cnt_q;

      // Any change of the synchronized word restarts the stability count.
      always_ff @(posedge clk) begin
        if (reset) begin
          cand_q <= '0;
          cnt_q  <= '0;
          data_q <= '0;
        end else if (s2_q != cand_q) begin
          cand_q <= s2_q;
          cnt_q  <= '0;
        end else if (cnt_q == CNT_LAST) begin
          data_q <= cand_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    ev = '0;
    case (EDGE_TYPE)
      0:       ev = data_q & ~data_dly_q;
      1:       ev = ~data_q & data_dly_q;
      default: ev = data_q ^ data_dly_q;
    endcase
  end

  always_comb begin
    clr        = '0;
    irq_mask_d = irq_mask_q;
    if (wr_en && address == 2'd3) clr = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd2) irq_mask_d = writedata[WIDTH-1:0];
    // A new edge wins over a same-cycle clear of that bit.
    edge_cap_d = ev | (edge_cap_q & ~clr);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = data_q;
      2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_dly_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata   <= '0;
    end else begin
      data_dly_q <= data_q;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata   <= readdata_d;
    end
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule
